// File: rtl/keypad_scanner_if.sv
// Keypad scanner pin bundle: matrix lines plus decoded key outputs.
// The scanner is the master; the consumer/keypad side is the slave.
interface keypad_scanner_if;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [3:0]  tecla;
    logic        tecla_valida;
    logic        tecla_presionada;
    logic [15:0] digitos;

    modport master (
        input  filas,
        output columnas,
        output tecla,
        output tecla_valida,
        output tecla_presionada,
        output digitos
    );

    modport slave (
        output filas,
        input  columnas,
        input  tecla,
        input  tecla_valida,
        input  tecla_presionada,
        input  digitos
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Emits a one-cycle strobe per accepted key and keeps a 4-key history.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1350,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int            DW      = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB      = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        ESCANEO, REBOTE, SOSTENIDA, LIBERA
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    s1_q, fs_q;
    logic [DW-1:0] div_q;
    logic [1:0]    col_q, col_d;
    logic [1:0]    fila_q, fila_d;
    logic [1:0]    colr_q, colr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    tecla_q, tecla_d;
    logic          valida_q, valida_d;
    logic          pres_q, pres_d;
    logic [15:0]   dig_q, dig_d;

    logic       tick, any_low, row_low, accept;
    logic [1:0] r;
    logic [3:0] cnt_inc, code;

    function automatic logic [3:0] key_code(
        input logic [1:0] row,
        input logic [1:0] col
    );
        logic [3:0] k;
        k = 4'h0;
        case ({row, col})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign tick    = (div_q == DIV_MAX);
    assign any_low = (fs_q != 4'hF);
    assign row_low = ~fs_q[fila_q];
    assign cnt_inc = cnt_q + 4'd1;

    // Lowest-index low row wins when several rows are low
    always_comb begin
        r = 2'd0;
        if (!fs_q[0])      r = 2'd0;
        else if (!fs_q[1]) r = 2'd1;
        else if (!fs_q[2]) r = 2'd2;
        else if (!fs_q[3]) r = 2'd3;
    end

    assign code = (state_q == ESCANEO) ? key_code(r, col_q)
                                       : key_code(fila_q, colr_q);

    assign accept = tick &&
        (((state_q == ESCANEO) && any_low && (DB == 4'd1)) ||
         ((state_q == REBOTE) && row_low && (cnt_inc >= DB)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ESCANEO;
            s1_q     <= 4'hF;
            fs_q     <= 4'hF;
            div_q    <= '0;
            col_q    <= 2'd0;
            fila_q   <= 2'd0;
            colr_q   <= 2'd0;
            cnt_q    <= 4'd0;
            tecla_q  <= 4'd0;
            valida_q <= 1'b0;
            pres_q   <= 1'b0;
            dig_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            s1_q     <= kp.filas;
            fs_q     <= s1_q;
            div_q    <= tick ? '0 : div_q + DW'(1);
            col_q    <= col_d;
            fila_q   <= fila_d;
            colr_q   <= colr_d;
            cnt_q    <= cnt_d;
            tecla_q  <= tecla_d;
            valida_q <= valida_d;
            pres_q   <= pres_d;
            dig_q    <= dig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                ESCANEO:
                    if (any_low)
                        state_d = (DB == 4'd1) ? SOSTENIDA : REBOTE;
                REBOTE:
                    if (!row_low)              state_d = ESCANEO;
                    else if (cnt_inc >= DB)    state_d = SOSTENIDA;
                SOSTENIDA:
                    if (!any_low)
                        state_d = (DB == 4'd1) ? ESCANEO : LIBERA;
                LIBERA:
                    if (any_low)               state_d = SOSTENIDA;
                    else if (cnt_inc >= DB)    state_d = ESCANEO;
                default: state_d = ESCANEO;
            endcase
        end
    end

    always_comb begin
        col_d    = col_q;
        fila_d   = fila_q;
        colr_d   = colr_q;
        cnt_d    = cnt_q;
        tecla_d  = tecla_q;
        valida_d = 1'b0;
        pres_d   = pres_q;
        dig_d    = dig_q;
        if (tick) begin
            case (state_q)
                ESCANEO:
                    if (any_low) begin
                        fila_d = r;
                        colr_d = col_q;
                        cnt_d  = 4'd1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                REBOTE:
                    if (row_low) cnt_d = cnt_inc;
                    else         col_d = col_q + 2'd1;
                SOSTENIDA:
                    if (!any_low) begin
                        cnt_d = 4'd1;
                        if (DB == 4'd1) begin
                            pres_d = 1'b0;
                            col_d  = col_q + 2'd1;
                        end
                    end
                LIBERA:
                    if (any_low) begin
                        cnt_d = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB) begin
                            pres_d = 1'b0;
                            col_d  = col_q + 2'd1;
                        end
                    end
                default: ;
            endcase
        end
        if (accept) begin
            valida_d = 1'b1;
            tecla_d  = code;
            dig_d    = {dig_q[11:0], code};
            pres_d   = 1'b1;
        end
    end

    assign kp.columnas         = ~(4'b0001 << col_q);
    assign kp.tecla            = tecla_q;
    assign kp.tecla_valida     = valida_q;
    assign kp.tecla_presionada = pres_q;
    assign kp.digitos          = dig_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural key matrix drives the rows
// from the scanned column; accepted keys are scored against a queue.
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp(kif)
    );

    typedef struct {
        logic [1:0]  r;
        logic [1:0]  c;
        logic [3:0]  code;
        logic [15:0] dig;
    } vec_t;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] dig;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] keys = 16'h0;
    logic [15:0] hist = 16'h0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          strobes  = 0;

    // Key at (row, col) shorts that row to the column line when driven
    always_comb begin
        kif.filas = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (keys[rr*4+cc] && !kif.columnas[cc])
                    kif.filas[rr] = 1'b0;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (kif.tecla_valida === 1'b1) begin
            exp_t e;
            strobes++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_tecla", kif.tecla, e.code);
                check("sb_digitos", kif.digitos, e.dig);
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_hold(logic [1:0] r, logic [1:0] c,
                              logic [3:0] code, int hold);
        int s0;
        s0 = strobes;
        hist = {hist[11:0], code};
        sb.push_back({code, hist});
        keys[r*4+c] = 1'b1;
        cycles(hold);
        check("one_strobe", strobes - s0, 1);
        check("tecla", kif.tecla, code);
        check("digitos", kif.digitos, hist);
        check("presionada_held", kif.tecla_presionada, 1'b1);
    endtask

    task automatic release_all();
        keys = 16'h0;
        cycles(24);
        check("presionada_rel", kif.tecla_presionada, 1'b0);
    endtask

    task automatic wait_col0_start();
        int n;
        n = 0;
        while (kif.columnas !== 4'b0111 && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (kif.columnas !== 4'b1110 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("col0_wait", kif.columnas, 4'b1110);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_columnas", kif.columnas, 4'b1110);
        check("rst_digitos", kif.digitos, 16'h0000);
        check("rst_valida", kif.tecla_valida, 1'b0);
        check("rst_tecla", kif.tecla, 4'h0);
        check("rst_presionada", kif.tecla_presionada, 1'b0);
        hist = 16'h0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t seq[5];

    initial begin
        int s0;
        seq[0] = '{2'd1, 2'd0, 4'h4, 16'h0004};
        seq[1] = '{2'd3, 2'd1, 4'h0, 16'h0040};
        seq[2] = '{2'd3, 2'd2, 4'hF, 16'h040F};
        seq[3] = '{2'd0, 2'd3, 4'hA, 16'h40FA};
        seq[4] = '{2'd2, 2'd0, 4'h7, 16'h0FA7};

        #1;
        check("init_columnas", kif.columnas, 4'b1110);
        check("init_tecla", kif.tecla, 4'h0);
        check("init_valida", kif.tecla_valida, 1'b0);
        check("init_presionada", kif.tecla_presionada, 1'b0);
        check("init_digitos", kif.digitos, 16'h0000);

        // Column walk after reset release, one step every 4 cycles
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            logic [3:0] e;
            e = ~(4'b0001 << ((k / 4) % 4));
            check("col_walk", kif.columnas, e);
            @(negedge clk);
        end

        // Single press: '6' at row 1, column 2
        press_hold(2'd1, 2'd2, 4'h6, 40);
        check("frozen_col", kif.columnas, 4'b1011);
        keys = 16'h0;
        cycles(4);
        check("frozen_col_rel", kif.columnas, 4'b1011);
        check("presionada_rel_pending", kif.tecla_presionada, 1'b1);
        cycles(20);
        check("presionada_rel", kif.tecla_presionada, 1'b0);

        // Mid-scan reset clears a non-empty history
        cycles(3);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            press_hold(seq[i].r, seq[i].c, seq[i].code, 40);
            check("seq_digitos", kif.digitos, seq[i].dig);
            release_all();
        end

        // Bounce: '1' seen on one tick only
        s0 = strobes;
        wait_col0_start();
        keys[0] = 1'b1;
        cycles(4);
        keys = 16'h0;
        cycles(4);
        check("bounce_resume_col1", kif.columnas, 4'b1101);
        check("bounce_no_strobe", strobes - s0, 0);
        check("bounce_presionada", kif.tecla_presionada, 1'b0);
        press_hold(2'd0, 2'd0, 4'h1, 40);
        release_all();

        // Two rows low in column 3, long hold, short release glitch
        s0 = strobes;
        hist = {hist[11:0], 4'hA};
        sb.push_back({4'hA, hist});
        keys[0*4+3] = 1'b1;
        keys[3*4+3] = 1'b1;
        cycles(100);
        check("multi_tecla", kif.tecla, 4'hA);
        check("multi_digitos", kif.digitos, 16'hA71A);
        check("multi_one_strobe", strobes - s0, 1);
        keys = 16'h0;
        cycles(6);
        check("glitch_presionada", kif.tecla_presionada, 1'b1);
        keys[0*4+3] = 1'b1;
        keys[3*4+3] = 1'b1;
        cycles(20);
        check("glitch_held", kif.tecla_presionada, 1'b1);
        check("glitch_no_strobe", strobes - s0, 1);
        release_all();

        // Reset while debouncing a press
        do_reset();
        s0 = strobes;
        wait_col0_start();
        keys[2*4+0] = 1'b1;
        cycles(6);
        #2 rst = 1'b0;
        #1;
        check("rebote_rst_valida", kif.tecla_valida, 1'b0);
        check("rebote_rst_digitos", kif.digitos, 16'h0000);
        keys = 16'h0;
        @(negedge clk);
        rst = 1'b1;
        cycles(40);
        check("rebote_no_strobe", strobes - s0, 0);
        check("rebote_digitos", kif.digitos, 16'h0000);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
